// File: rtl/apb_cmd_master.sv
// APB4 requester: turns one valid/ready command into one SETUP/ACCESS transfer and returns a response.
// Optional ACCESS-phase watchdog enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1, waiting on pready (or watchdog)
// RESP   | rsp_valid high until rsp_ready
module apb_cmd_master #(
  parameter int REGWIDTH       = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [REGWIDTH-1:0]     cmd_wdata,
  input  logic [REGWIDTH/8-1:0]   cmd_wstrb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [REGWIDTH-1:0]     rsp_rdata,
  output logic                    rsp_err,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [REGWIDTH-1:0]     m_apb_pwdata,
  output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic [REGWIDTH-1:0]     m_apb_prdata,
  input  logic                    m_apb_pslverr
);

  if (((REGWIDTH % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
    $error("apb_cmd_master: REGWIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   cmd_fire;
  logic   rsp_fire;
  logic   done;
  logic   abort;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign done     = (state == ACCESS) && m_apb_pready;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == SETUP) begin
      wd_cnt <= '0;
    end else if ((state == ACCESS) && !m_apb_pready) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the wait cycle that would bring the count to the limit; pready wins.
  assign abort = (state == ACCESS) && !m_apb_pready && (wd_cnt == CNT_LAST);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_pprot   <= '0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cmd_ready    <= 1'b0;
            m_apb_psel   <= 1'b1;
            m_apb_pwrite <= cmd_write;
            m_apb_pprot  <= cmd_prot;
            m_apb_paddr  <= cmd_addr;
            m_apb_pwdata <= cmd_write ? cmd_wdata : '0;
            m_apb_pstrb  <= cmd_write ? cmd_wstrb : '0;
          end
        end
        SETUP: m_apb_penable <= 1'b1;
        ACCESS: begin
          if (done || abort) begin
            // paddr/pprot keep their last value once the bus goes idle
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_pwdata  <= '0;
            m_apb_pstrb   <= '0;
            rsp_valid     <= 1'b1;
            rsp_err       <= done ? m_apb_pslverr : 1'b1;
            rsp_rdata     <= (done && !m_apb_pwrite) ? m_apb_prdata : '0;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: vector table driven through a scoreboard queue,
// plus hand-written reset-in-ACCESS and watchdog sequences.
module tb_apb_cmd_master;
  localparam int RW = 64;
  localparam int AW = 8;
  localparam int SW = RW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [RW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [RW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [2:0]    pprot;
  logic [AW-1:0] paddr;
  logic [RW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;

  apb_cmd_master #(.REGWIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
    .m_apb_pprot(pprot), .m_apb_paddr(paddr), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
    .m_apb_pready(pready), .m_apb_prdata(prdata), .m_apb_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [RW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;
    logic [RW-1:0] prdata;
    logic          slverr;
    int            rsp_delay;
    logic [RW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [RW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [RW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t sb_q[$];
  vec_t tbl[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] wdata,
                              input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                              input logic [RW-1:0] prd, input logic slverr, input int rsp_delay,
                              input logic [RW-1:0] exp_pwdata, input logic [SW-1:0] exp_pstrb,
                              input logic [RW-1:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.waits = waits; v.prdata = prd; v.slverr = slverr; v.rsp_delay = rsp_delay;
    v.exp_pwdata = exp_pwdata; v.exp_pstrb = exp_pstrb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic run_txn(input vec_t v);
    rsp_t e;
    rsp_t got;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.strb; cmd_prot = v.prot;
    chk("idle_cmd_ready", cmd_ready, 1);
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.wr);
    chk("setup_pprot", pprot, v.prot);
    chk("setup_pwdata", pwdata, v.exp_pwdata);
    chk("setup_pstrb", pstrb, v.exp_pstrb);
    prdata = v.prdata; pslverr = v.slverr;
    for (int w = 0; w <= v.waits; w++) begin
      @(negedge clk);
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_rsp_valid", rsp_valid, 0);
      chk("access_pwdata", pwdata, v.exp_pwdata);
      chk("access_pstrb", pstrb, v.exp_pstrb);
      chk("access_paddr", paddr, v.addr);
      pready = (w == v.waits);
    end
    @(negedge clk);
    pready = 1'b0; prdata = ~v.prdata; pslverr = ~v.slverr;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_pwrite", pwrite, 0);
    chk("resp_pwdata", pwdata, 0);
    chk("resp_pstrb", pstrb, 0);
    chk("resp_paddr_hold", paddr, v.addr);
    chk("resp_pprot_hold", pprot, v.prot);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      got.rdata = '0; got.err = 1'b0;
    end else begin
      got = sb_q.pop_front();
    end
    chk("rsp_rdata", rsp_rdata, got.rdata);
    chk("rsp_err", rsp_err, got.err);
    for (int d = 0; d < v.rsp_delay; d++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, got.rdata);
      chk("hold_rsp_err", rsp_err, got.err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", psel, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_psel", psel, 0);
  endtask

  initial begin
    int n_acc;
    tbl[0] = mk(1'b1, 8'h08, 64'h1122334455667788, 8'hFF, 3'b000, 0, 64'hAAAA5555AAAA5555, 1'b0, 0,
                64'h1122334455667788, 8'hFF, 64'h0, 1'b0);
    tbl[1] = mk(1'b0, 8'hF8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'b101, 3, 64'hDEADBEEFCAFEF00D, 1'b0, 0,
                64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0);
    tbl[2] = mk(1'b0, 8'h10, 64'h0, 8'h00, 3'b001, 1, 64'h0123456789ABCDEF, 1'b1, 0,
                64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b1);
    tbl[3] = mk(1'b1, 8'h33, 64'hCAFE0000BEEF1234, 8'h0F, 3'b010, 2, 64'h5A5A5A5A5A5A5A5A, 1'b1, 0,
                64'hCAFE0000BEEF1234, 8'h0F, 64'h0, 1'b1);
    tbl[4] = mk(1'b0, 8'h40, 64'h0, 8'h00, 3'b111, 0, 64'h8000000000000001, 1'b0, 5,
                64'h0, 8'h00, 64'h8000000000000001, 1'b0);
    tbl[5] = mk(1'b1, 8'h48, 64'h00000000FFFFFFFF, 8'hF0, 3'b100, 0, 64'h1, 1'b0, 0,
                64'h00000000FFFFFFFF, 8'hF0, 64'h0, 1'b0);

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pprot", pprot, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // reset while stalled in ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_prot = 3'b011;
    @(negedge clk);
    cmd_valid = 1'b0; pready = 1'b0;
    @(negedge clk);
    chk("rstacc_penable", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc_psel", psel, 0);
    chk("rstacc_penable_after", penable, 0);
    chk("rstacc_rsp_valid", rsp_valid, 0);
    chk("rstacc_cmd_ready", cmd_ready, 1);
    run_txn(mk(1'b1, 8'h18, 64'h0F0F0F0F0F0F0F0F, 8'h3C, 3'b000, 1, 64'h77, 1'b0, 0,
               64'h0F0F0F0F0F0F0F0F, 8'h3C, 64'h0, 1'b0));

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'hA0; cmd_prot = 3'b000;
    @(negedge clk);
    cmd_valid = 1'b0; pready = 1'b0; prdata = 64'hFEEDFACE12345678; pslverr = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (psel && penable) n_acc++;
      else break;
    end
    chk("to_access_cycles", n_acc, TO);
    chk("to_psel", psel, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_post_rsp_valid", rsp_valid, 0);
    chk("to_post_cmd_ready", cmd_ready, 1);
`else
    n_acc = 0;
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
